event_packetizer: RTL
=====================

# event_packetizer

Readout end of the pixel arbitration hierarchy. Each cycle the top-level arbiter reports a granted pixel with `active_o` and the `x_add_o`/`y_add_o` address. This block timestamps each grant and buffers it in a small FIFO. It streams events out over a valid/ready handshake and asserts a hold back to the arbiter when the buffer nears full, so grants stop before events are lost.

## Interface
Parameters:
- `X_W`, 4, column address width
- `Y_W`, 4, row address width
- `TS_W`, 16, timestamp width
- `DEPTH`, 8, FIFO depth in entries (power of 2, ≥4)
- `HOLD_LVL`, 6, fill level at or above which `hold_o` asserts (1..DEPTH)
- `DROP_W`, 8, width of the dropped-event counter

Ports:
- `clk_i` in 1: single clock, all logic on rising edge
- `reset_i` in 1: synchronous, active-high reset
- `active_i` in 1: a grant is valid this cycle
- `x_add_i` in X_W: granted column address
- `y_add_i` in Y_W: granted row address
- `evt_data_o` out D_W: event word {ts, y, x}. D_W = TS_W+Y_W+X_W, or Y_W+X_W without the timestamp (see Configuration)
- `evt_valid_o` out 1: head entry valid
- `evt_ready_i` in 1: downstream accepts the head entry
- `hold_o` out 1: stall request to the arbiter
- `level_o` out $clog2(DEPTH)+1: current FIFO occupancy
- `drop_cnt_o` out DROP_W: saturating count of grants lost while the FIFO is full

## Operation
- **Timestamp counter `ts`**
  - Reset value is 0.
  - Increments by 1 every cycle and wraps modulo 2^TS_W.
  - Value is 0 in the first cycle with `reset_i` low.
- **Push**
  - Push occurs when `active_i`=1 and `level` < DEPTH, with `level` taken from the start-of-cycle register value.
  - The word written is {ts, y_add_i, x_add_i} as sampled in that cycle.
- **Pop**
  - Pop occurs when `evt_valid_o`=1 and `evt_ready_i`=1.
- **Simultaneous push and pop**
  - Both happen and `level` is unchanged.
  - When full, a simultaneous pop does NOT enable the push. The grant is dropped. This keeps full-detection registered.
- **Drop**
  - `active_i`=1 with `level`==DEPTH increments `drop_cnt_o`.
  - The counter saturates at 2^DROP_W−1 and clears only on reset.
- **Pointers**
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally.
  - Occupancy is tracked in a separate `level` register, 0..DEPTH.
- **Outputs**
  - `evt_valid_o` = (`level` != 0).
  - `evt_data_o` = entry at the read pointer (show-ahead). It is don't-care when not valid.
- **`hold_o`**
  - `hold_o` = (`level` ≥ HOLD_LVL), driven from the registered `level`.
  - The arbiter has one cycle of response slack; DEPTH−HOLD_LVL ≥ 1 absorbs the in-flight grant.
- **Handshake rules**
  - While `evt_valid_o`=1 and `evt_ready_i`=0, `evt_data_o` and `evt_valid_o` hold stable.
  - `evt_valid_o` never drops without a pop.
- **Reset mid-operation**
  - All entries are discarded: `level`=0, pointers=0, `ts`=0, `drop_cnt_o`=0.
  - A grant present in the reset cycle is ignored.
  - FIFO storage is not reset.

## Timing
- Reset values of outputs:
  - `evt_valid_o`=0, `hold_o`=0, `level_o`=0, `drop_cnt_o`=0.
  - `evt_data_o` is undefined.
- Latency: grant in cycle N into an empty FIFO gives `evt_valid_o`=1 in cycle N+1, carrying ts=N.
- Throughput: one push and one pop per cycle, sustained.
- `hold_o` reflects a push from cycle N in cycle N+1.
- `drop_cnt_o` and `level_o` update at the edge ending the cycle of the event.

## Configuration
- **`EVT_TS_EN` defined:**
  - The timestamp counter is present.
  - D_W = TS_W+Y_W+X_W and `evt_data_o` = {ts, y, x}.
- **`EVT_TS_EN` undefined:**
  - No timestamp counter is built and `TS_W` is ignored.
  - D_W = Y_W+X_W and `evt_data_o` = {y, x}.
  - All other behaviour is identical.

## Test plan
- **Single event** (EVT_TS_EN, defaults): reset released, then `active_i`=1 with x=3, y=7 in cycle 5 and `evt_ready_i`=1 → `evt_valid_o`=1 in cycle 6, `evt_data_o`=24'h000573. The event pops in cycle 6 and `level_o` returns to 0 in cycle 7.
- **Fill and hold**: `evt_ready_i`=0, grants in 8 consecutive cycles with x=y=i (i=0..7) → `hold_o` rises the cycle after the 6th push and `level_o`=8. A 9th grant increments `drop_cnt_o` to 1.
- **Full with pop**: with the FIFO full, assert `active_i` and `evt_ready_i` in the same cycle → the pop occurs, the grant is dropped, `level_o`=7 and `drop_cnt_o` increments.
- **Backpressure ordering**: 4 grants, then `evt_ready_i` toggled 1010… → 4 events out in push order with addresses unchanged and data stable during stalls.
- **Saturation and wrap**: 300 grants while full (DROP_W=8) → `drop_cnt_o`=255. Let `ts` run 2^16+3 cycles and then push → ts field=3.
- **Reset mid-stream**: 5 entries queued, `reset_i` high for 1 cycle with `active_i`=1 → next cycle `evt_valid_o`=0, `level_o`=0, `drop_cnt_o`=0, and no event is emitted for the reset-cycle grant.

Source files
------------

// File: rtl/event_packetizer.sv
// Timestamps pixel-arbiter grants, buffers them in a show-ahead FIFO and streams them out over valid/ready.
// Optional feature: define EVT_TS_EN to build the timestamp counter and prepend ts to each event word.
module event_packetizer #(
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int TS_W     = 16,
  parameter int DEPTH    = 8,
  parameter int HOLD_LVL = 6,
  parameter int DROP_W   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       active_i,
  input  logic [X_W-1:0]             x_add_i,
  input  logic [Y_W-1:0]             y_add_i,
`ifdef EVT_TS_EN
  output logic [TS_W+Y_W+X_W-1:0]    evt_data_o,
`else
  output logic [Y_W+X_W-1:0]         evt_data_o,
`endif
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic                       hold_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef EVT_TS_EN
  localparam int D_W = TS_W + Y_W + X_W;
`else
  localparam int D_W = Y_W + X_W;
`endif

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("event_packetizer: DEPTH must be a power of 2 and >= 4");
  end
  if (HOLD_LVL < 1 || HOLD_LVL > DEPTH) begin : g_bad_hold
    $error("event_packetizer: HOLD_LVL must be in 1..DEPTH");
  end
  if (TS_W < 1) begin : g_bad_ts
    $error("event_packetizer: TS_W must be at least 1");
  end

  logic [D_W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [D_W-1:0]    wr_word;
  logic              full, push, pop;

  // Full is judged on the registered level only, so a same-cycle pop never frees room for a grant.
  assign full = (level_q == LW'(DEPTH));
  assign push = active_i && !full && !reset_i;
  assign pop  = evt_valid_o && evt_ready_i;

`ifdef EVT_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ts_q <= '0;
    else         ts_q <= ts_d;
  end

  assign wr_word = {ts_q, y_add_i, x_add_i};
`else
  assign wr_word = {y_add_i, x_add_i};
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (active_i && full && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + DROP_W'(1);
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: storage has no reset; level gates validity, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_word;
  end

  assign evt_data_o  = mem_q[rd_ptr_q];
  assign evt_valid_o = (level_q != '0);
  assign hold_o      = (level_q >= LW'(HOLD_LVL));
  assign level_o     = level_q;
  assign drop_cnt_o  = drop_q;

endmodule
